// File: rtl/seq_mul8_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
interface seq_mul8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             ovf;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, prod_lo, prod_hi, ovf
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output busy, done, prod_lo, prod_hi, ovf
  );
endinterface

// File: rtl/seq_mul8.sv
// Multi-cycle unsigned shift-add multiplier: one partial-product step per clock,
// full 2*WIDTH-bit product registered on completion with a one-cycle done pulse.
module seq_mul8 #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  seq_mul8_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  // Next-state logic: operand capture, one add-and-shift per RUN cycle, result latch.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    ovf_d     = ovf_q;
    sum       = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          hi_d    = '0;
          lo_d    = bus.b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        // {hi,lo} <= {sum,lo} >> 1, split so no intermediate 2W+1 vector is needed
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          prod_hi_d = sum[WIDTH:1];
          prod_lo_d = {sum[0], lo_q[WIDTH-1:1]};
          ovf_d     = |sum[WIDTH:1];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset discarding any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      ovf_q     <= ovf_d;
    end
  end

  // Status decodes straight from the state; result comes from the held registers.
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.prod_lo = prod_lo_q;
    bus.prod_hi = prod_hi_q;
    bus.ovf     = ovf_q;
  end

endmodule

// File: tb/tb_seq_mul8.sv
// Self-checking bench for seq_mul8: cycle-level reference model plus directed
// literal checks and a long randomized back-to-back stream.
module tb_seq_mul8;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  seq_mul8_if #(.WIDTH(W)) bus ();

  seq_mul8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts edges since an accepted start and publishes a*b
  // after W+1 edges (counting the accept edge), then returns to idle.
  int          m_phase = 0;
  logic [15:0] m_pend  = '0;
  logic [15:0] m_prod  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_prod  <= '0;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_pend  <= 16'(bus.a) * 16'(bus.b);
        m_phase <= 1;
      end
    end else if (m_phase == W) begin
      m_prod  <= m_pend;
      m_phase <= W + 1;
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(bus.busy),    32'(m_phase != 0));
      check("done",    32'(bus.done),    32'(m_phase == W + 1));
      check("prod_lo", 32'(bus.prod_lo), 32'(m_prod[7:0]));
      check("prod_hi", 32'(bus.prod_hi), 32'(m_prod[15:8]));
      check("ovf",     32'(bus.ovf),     32'(m_prod[15:8] != 8'h00));
    end
  end

  // Issue one op, measure edges until done (accept edge counts as 1), check literals.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input logic exp_ovf);
    int lat;
    @(negedge clk);
    bus.a = x; bus.b = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("lit_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'(exp));
    check("lit_ovf", 32'(bus.ovf), 32'(exp_ovf));
    repeat (3) @(negedge clk);
    check("held_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'(exp));
    check("held_done", 32'(bus.done), 32'(0));
  endtask

  initial begin
    int dones;
    int wait_cyc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    // Reset for two cycles, then idle.
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'h0000);
    check("rst_ovf",  32'(bus.ovf), 32'(0));

    // Directed products.
    run_op(8'h0F, 8'h11, 16'h00FF, 1'b0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    run_op(8'h00, 8'hA5, 16'h0000, 1'b0);
    run_op(8'h10, 8'h10, 16'h0100, 1'b1);

    // Start while busy is ignored.
    @(negedge clk);
    bus.a = 8'd3; bus.b = 8'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.a = 8'd9; bus.b = 8'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc = 0;
    while (!bus.done && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("ign_done", 32'(bus.done), 32'(1));
    check("ign_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'h0015);
    check("ign_busy", 32'(bus.busy), 32'(1));
    @(negedge clk);
    check("ign_single", 32'(bus.done), 32'(0));
    repeat (3) @(negedge clk);

    // Reset mid-operation discards the op.
    bus.a = 8'hC8; bus.b = 8'h02; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'(0));
    check("mrst_done", 32'(bus.done), 32'(0));
    check("mrst_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'h0000);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mrst_nodone", 32'(dones), 32'(0));
    run_op(8'h02, 8'h03, 16'h0006, 1'b0);

    // Start held high: back-to-back ops every W+2 cycles.
    @(negedge clk);
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.start = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      if (bus.done) dones++;
    end
    check("b2b_count", 32'(dones), 32'(4));

    // Long random stream, roughly 1000 operations.
    repeat (1000 * (W + 2)) begin
      @(negedge clk);
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      bus.start = ($urandom_range(0, 15) != 0);
    end
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
